bram_reader: RTL and testbench
==============================

BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, BRAM address width in bits.
REQ-002 Parameter RAM_DEPTH, default 2**ADDR_WIDTH, number of BRAM words.
REQ-003 Parameter DATA_WIDTH, default 32, BRAM word width in bits.
REQ-004 Port clk  in  1  single clock for all logic; the BRAM read port rdclk is tied to this same clock.
REQ-005 Port srst  in  1  reset, synchronous to clk and active-high.
REQ-006 Port cmd_valid  in  1  command request.
REQ-007 Port cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a clk edge.
REQ-008 Port cmd_addr  in  ADDR_WIDTH  first word address.
REQ-009 Port cmd_len  in  ADDR_WIDTH+1  word count, 0..RAM_DEPTH.
REQ-010 Port rden  out  1  BRAM read enable.
REQ-011 Port rdaddr  out  ADDR_WIDTH  BRAM read address.
REQ-012 Port rddata  in  DATA_WIDTH  BRAM read data, valid one cycle after rden (READ_NB_FFD=1), held while rden is low.
REQ-013 Port m_valid  out  1  stream data valid.
REQ-014 Port m_ready  in  1  stream consumer ready.
REQ-015 Port m_data  out  DATA_WIDTH  stream word.
REQ-016 Port m_last  out  1  final word of the current command.
REQ-017 Port busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-018 FSM states: IDLE, READ, DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-019 Transitions: IDLE->READ on a command with cmd_len>0; READ->DRAIN on the cycle the last rden is issued; DRAIN->IDLE on the cycle m_valid&m_ready&m_last.
REQ-020 cmd_len=0 SHALL be accepted and dropped: the FSM stays IDLE, and no rden or m_valid is produced.
REQ-021 The first rden SHALL assert in the cycle after command acceptance with rdaddr=cmd_addr; read i SHALL use address (cmd_addr+i) mod RAM_DEPTH, wrapping from RAM_DEPTH-1 to 0, including when RAM_DEPTH is not a power of 2.
REQ-022 Exactly cmd_len rden pulses SHALL be issued per command.
REQ-023 rddata SHALL be captured into a 2-entry output buffer only on the cycle following an rden pulse.
REQ-024 rden SHALL assert only when (buffered words + in-flight reads) < 2, so no word is ever dropped or overwritten.
REQ-025 With m_ready held at 1, throughput SHALL be 1 word/cycle, and the first m_valid SHALL assert 2 cycles after command acceptance.
REQ-026 m_data and m_last SHALL be held stable while m_valid=1 and m_ready=0; words SHALL leave in address order.
REQ-027 m_last SHALL be 1 only on word cmd_len-1 of the command.
REQ-028 A simultaneous buffer push and pop SHALL leave the occupancy unchanged and lose no data.
REQ-029 busy SHALL be 1 from the cycle after acceptance until the cycle after the m_last handshake.

Reset
REQ-030 While srst=1: FSM=IDLE; cmd_ready=0, rden=0, rdaddr=0, m_valid=0, m_last=0, m_data=0, busy=0; buffer and counters cleared.
REQ-031 srst during a transfer SHALL abort it immediately, and in-flight BRAM data SHALL be discarded.
REQ-032 cmd_ready SHALL rise in the first cycle after srst deasserts.

Structure
REQ-033 The FSM state enum typedef SHALL reside in the shared package bram_pkg.
REQ-034 The 2-entry output buffer SHALL be the sub-module bram_reader_buf, with ports clk, srst, push, din, pop, dout, count.
REQ-035 The BRAM itself SHALL NOT be instantiated inside bram_reader; the bench connects it.

Verification
REQ-036 Test 1: cmd_addr=0x10, cmd_len=4, m_ready=1 -> rden in cycles 1-4 at 0x10-0x13; m_valid in cycles 2-5; m_last only in cycle 5.
REQ-037 Test 2: ADDR_WIDTH=8, cmd_addr=0xFE, cmd_len=4 -> reads at 0xFE, 0xFF, 0x00, 0x01; for RAM_DEPTH=200, cmd_addr=198, cmd_len=3 -> reads at 198, 199, 0.
REQ-038 Test 3: cmd_len=8 with m_ready toggling 1,0,0,1 repeating -> all 8 words in order, none duplicated, and no rden while 2 words are held.
REQ-039 Test 4: cmd_len=0 -> cmd_ready stays 1, busy stays 0, and no rden or m_valid occurs.
REQ-040 Test 5: cmd_len=256 (full depth) -> 256 words delivered, m_last on word 255, then cmd_ready=1.
REQ-041 Test 6: srst pulsed mid-transfer after 3 of 10 words -> all outputs at reset values the next cycle; a following cmd_len=2 command completes correctly.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types for the BRAM reader: FSM state encoding and output buffer depth.
package bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } bram_state_e;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/bram_reader_buf.sv
// Two-entry fall-through buffer: when empty, din appears on dout in the same cycle,
// so a push and pop together pass the word straight through without storing it.
module bram_reader_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            count_r;
  logic                  empty_s;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // Write/read enables and the bypass data path.
  always_comb begin
    empty_s = (count_r == 2'd0);
    wr_en_s = push & ~(empty_s & pop);
    rd_en_s = pop & ~empty_s;
    if (empty_s) begin
      dout = din;
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      mem_r[0] <= {DATA_WIDTH{1'b0}};
      mem_r[1] <= {DATA_WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;

endmodule

// File: rtl/bram_reader.sv
// Streams cmd_len consecutive BRAM words (wrapping at RAM_DEPTH) out of a
// one-cycle-latency read port onto a valid/ready stream with m_last framing.
module bram_reader
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0] rddata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);

  bram_state_e           state_r;
  bram_state_e           state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [ADDR_WIDTH:0]   remain_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   out_cnt_r;
  logic                  inflight_r;
  logic                  issue_s;
  logic                  avail_s;
  logic                  hs_s;
  logic                  last_word_s;
  logic [DATA_WIDTH-1:0] buf_dout_s;
  logic [1:0]            buf_count_s;

  // Read issue gating, stream handshake and next-state decode.
  always_comb begin
    state_s     = state_r;
    next_addr_s = (addr_r == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : addr_r + ADDR_WIDTH'(1);
    // Buffered plus in-flight words must stay within buffer capacity.
    issue_s     = (state_r == ST_READ) && (remain_r != {(ADDR_WIDTH+1){1'b0}}) &&
                  (({1'b0, buf_count_s} + {2'b00, inflight_r}) < 3'(BUF_DEPTH));
    avail_s     = (buf_count_s != 2'd0) || inflight_r;
    hs_s        = avail_s && m_ready;
    last_word_s = (out_cnt_r == (len_r - LEN_ONE));
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && (cmd_len != {(ADDR_WIDTH+1){1'b0}})) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issue_s && (remain_r == LEN_ONE)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (hs_s && last_word_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, address/length counters and read-return tracking.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      remain_r   <= {(ADDR_WIDTH+1){1'b0}};
      len_r      <= {(ADDR_WIDTH+1){1'b0}};
      out_cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= issue_s;
      if ((state_r == ST_IDLE) && cmd_valid) begin
        addr_r    <= cmd_addr;
        remain_r  <= cmd_len;
        len_r     <= cmd_len;
        out_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
      end else begin
        if (issue_s) begin
          addr_r   <= next_addr_s;
          remain_r <= remain_r - LEN_ONE;
        end else begin
          addr_r   <= addr_r;
          remain_r <= remain_r;
        end
        if (hs_s) begin
          out_cnt_r <= out_cnt_r + LEN_ONE;
        end else begin
          out_cnt_r <= out_cnt_r;
        end
      end
    end
  end

  bram_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .srst  (srst),
    .push  (inflight_r),
    .din   (rddata),
    .pop   (hs_s),
    .dout  (buf_dout_s),
    .count (buf_count_s)
  );

  // srst forces every output to its idle value within the same cycle.
  always_comb begin
    cmd_ready = ~srst && (state_r == ST_IDLE);
    busy      = ~srst && (state_r != ST_IDLE);
    rden      = ~srst && issue_s;
    rdaddr    = srst ? {ADDR_WIDTH{1'b0}} : addr_r;
    m_valid   = ~srst && avail_s;
    m_last    = ~srst && avail_s && last_word_s;
    if (~srst && avail_s) begin
      m_data = buf_dout_s;
    end else begin
      m_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_bram_reader.sv
// Directed bench for bram_reader: two instances (256-word and 200-word BRAM)
// with behavioural one-cycle-latency BRAM models and a stream monitor.
module tb_bram_reader;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        cmd_valid_a = 1'b0;
  logic        cmd_valid_b = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [8:0]  cmd_len = 9'd0;
  logic        m_ready = 1'b1;
  logic        cmd_ready_a, rden_a, m_valid_a, m_last_a, busy_a;
  logic [7:0]  rdaddr_a;
  logic [31:0] rddata_a = 32'h0, m_data_a;
  logic        cmd_ready_b, rden_b, m_valid_b, m_last_b, busy_b;
  logic [7:0]  rdaddr_b;
  logic [31:0] rddata_b = 32'h0, m_data_b;

  int checks = 0;
  int failures = 0;
  logic [3:0] ready_pat = 4'b1111;
  int pidx = 0;

  always #5 clk = ~clk;

  bram_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut (
    .clk(clk), .srst(srst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rden(rden_a), .rdaddr(rdaddr_a),
    .rddata(rddata_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
    .m_last(m_last_a), .busy(busy_a));

  bram_reader #(.ADDR_WIDTH(8), .RAM_DEPTH(200), .DATA_WIDTH(32)) u_dut200 (
    .clk(clk), .srst(srst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rden(rden_b), .rdaddr(rdaddr_b),
    .rddata(rddata_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .m_last(m_last_b), .busy(busy_b));

  function automatic logic [31:0] memval(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  // BRAM models: data one cycle after rden, held otherwise.
  always @(posedge clk) begin
    if (rden_a) rddata_a <= memval(rdaddr_a);
    if (rden_b) rddata_b <= memval(rdaddr_b);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the 256-word instance with an independent occupancy model.
  int acc_cyc = 0, rd_n = 0, hs_n = 0, held = 0;
  int full_viol = 0, ovf_viol = 0, valid_viol = 0, stab_viol = 0;
  logic [7:0]  rd_addr [512];
  int          rd_cyc  [512];
  logic [31:0] hs_data [512];
  logic        hs_last [512];
  int          hs_cyc  [512];
  logic        rden_prev = 1'b0, stall_pend = 1'b0, stall_last = 1'b0;
  logic [31:0] stall_data = 32'h0;
  wire         hs_a = m_valid_a & m_ready;

  always @(negedge clk) begin
    if (srst) begin
      held <= 0;
      rden_prev <= 1'b0;
      stall_pend <= 1'b0;
    end else begin
      if (cmd_valid_a && cmd_ready_a) acc_cyc <= cyc;
      if (rden_a) begin
        rd_addr[rd_n] <= rdaddr_a;
        rd_cyc[rd_n]  <= cyc;
        rd_n <= rd_n + 1;
        if (held >= 2) full_viol <= full_viol + 1;
      end
      if (held + int'(rden_prev) > 2) ovf_viol <= ovf_viol + 1;
      if (m_valid_a != (held + int'(rden_prev) > 0)) valid_viol <= valid_viol + 1;
      held <= held + int'(rden_prev) - int'(hs_a);
      if (hs_a) begin
        hs_data[hs_n] <= m_data_a;
        hs_last[hs_n] <= m_last_a;
        hs_cyc[hs_n]  <= cyc;
        hs_n <= hs_n + 1;
      end
      if (stall_pend && m_valid_a && (m_data_a != stall_data || m_last_a != stall_last))
        stab_viol <= stab_viol + 1;
      stall_pend <= m_valid_a && !m_ready;
      stall_data <= m_data_a;
      stall_last <= m_last_a;
      rden_prev  <= rden_a;
    end
  end

  // Monitor for the 200-word instance.
  int rdb_n = 0, hsb_n = 0;
  logic [7:0]  rdb_addr [16];
  logic [31:0] hsb_data [16];
  logic        hsb_last [16];
  always @(negedge clk) begin
    if (!srst) begin
      if (rden_b && rdb_n < 16) begin
        rdb_addr[rdb_n] <= rdaddr_b;
        rdb_n <= rdb_n + 1;
      end
      if (m_valid_b && m_ready && hsb_n < 16) begin
        hsb_data[hsb_n] <= m_data_b;
        hsb_last[hsb_n] <= m_last_b;
        hsb_n <= hsb_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_ready = ready_pat[pidx];
    pidx = (pidx + 1) % 4;
  endtask

  task automatic start_cmd(input logic [7:0] a, input logic [8:0] l, input bit use_b);
    cmd_addr = a;
    cmd_len  = l;
    if (use_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    tick();
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget, input bit use_b, input string tag);
    int n;
    n = 0;
    while ((use_b ? hsb_n : hs_n) < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, use_b ? hsb_n : hs_n, target);
  endtask

  initial begin
    int r0, h0, bad;
    logic [7:0] a;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready_a, 1'b0);
    check("rst_rden", rden_a, 1'b0);
    check("rst_rdaddr", rdaddr_a, 8'h00);
    check("rst_m_valid", m_valid_a, 1'b0);
    check("rst_m_last", m_last_a, 1'b0);
    check("rst_m_data", m_data_a, 32'h0);
    check("rst_busy", busy_a, 1'b0);
    tick();
    srst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", cmd_ready_a, 1'b1);

    // Test 1: basic 4-word read, full throughput
    r0 = rd_n; h0 = hs_n;
    start_cmd(8'h10, 9'd4, 1'b0);
    @(negedge clk);
    check("t1_busy", busy_a, 1'b1);
    wait_words(h0 + 4, 40, 1'b0, "t1_done");
    @(negedge clk);
    check("t1_ready_after", cmd_ready_a, 1'b1);
    check("t1_busy_after", busy_a, 1'b0);
    check("t1_nreads", rd_n - r0, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_rdaddr", rd_addr[r0+i], 8'h10 + 8'(i));
      check("t1_rdcyc", rd_cyc[r0+i] - acc_cyc, i + 1);
      check("t1_data", hs_data[h0+i], memval(8'h10 + 8'(i)));
      check("t1_vcyc", hs_cyc[h0+i] - acc_cyc, i + 2);
      check("t1_last", hs_last[h0+i], (i == 3) ? 1'b1 : 1'b0);
    end

    // Test 2a: wrap at 0xFF
    r0 = rd_n; h0 = hs_n;
    start_cmd(8'hFE, 9'd4, 1'b0);
    wait_words(h0 + 4, 40, 1'b0, "t2_done");
    check("t2_rd0", rd_addr[r0+0], 8'hFE);
    check("t2_rd1", rd_addr[r0+1], 8'hFF);
    check("t2_rd2", rd_addr[r0+2], 8'h00);
    check("t2_rd3", rd_addr[r0+3], 8'h01);
    check("t2_data2", hs_data[h0+2], memval(8'h00));

    // Test 2b: non-power-of-2 depth wrap
    start_cmd(8'd198, 9'd3, 1'b1);
    wait_words(3, 40, 1'b1, "t2b_done");
    tick(); tick();
    check("t2b_nreads", rdb_n, 3);
    check("t2b_rd0", rdb_addr[0], 8'd198);
    check("t2b_rd1", rdb_addr[1], 8'd199);
    check("t2b_rd2", rdb_addr[2], 8'd0);
    check("t2b_data2", hsb_data[2], memval(8'd0));
    check("t2b_last", hsb_last[2], 1'b1);

    // Test 3: backpressure 1,0,0,1
    @(negedge clk);
    r0 = rd_n; h0 = hs_n;
    ready_pat = 4'b1001; pidx = 0;
    start_cmd(8'h30, 9'd8, 1'b0);
    wait_words(h0 + 8, 100, 1'b0, "t3_done");
    ready_pat = 4'b1111;
    tick(); tick(); tick();
    check("t3_nwords", hs_n - h0, 8);
    check("t3_nreads", rd_n - r0, 8);
    for (int i = 0; i < 8; i++) begin
      check("t3_data", hs_data[h0+i], memval(8'h30 + 8'(i)));
      check("t3_last", hs_last[h0+i], (i == 7) ? 1'b1 : 1'b0);
    end
    check("t3_rden_full", full_viol, 0);
    check("t3_overflow", ovf_viol, 0);
    check("t3_stable", stab_viol, 0);

    // Test 4: zero-length command dropped
    @(negedge clk);
    r0 = rd_n; h0 = hs_n; bad = 0;
    start_cmd(8'h77, 9'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!cmd_ready_a || busy_a || rden_a || m_valid_a) bad++;
      tick();
    end
    check("t4_idle", bad, 0);
    check("t4_nreads", rd_n - r0, 0);
    check("t4_nwords", hs_n - h0, 0);

    // Test 5: full-depth command
    @(negedge clk);
    r0 = rd_n; h0 = hs_n; bad = 0;
    start_cmd(8'h80, 9'd256, 1'b0);
    wait_words(h0 + 256, 400, 1'b0, "t5_done");
    @(negedge clk);
    check("t5_ready_after", cmd_ready_a, 1'b1);
    for (int i = 0; i < 256; i++) begin
      a = 8'h80 + 8'(i);
      if (hs_data[h0+i] != memval(a) || rd_addr[r0+i] != a) bad++;
      if (hs_last[h0+i] != (i == 255)) bad++;
    end
    check("t5_words", bad, 0);
    check("t5_last255", hs_last[h0+255], 1'b1);
    check("t5_lastcyc", hs_cyc[h0+255] - acc_cyc, 257);

    // Test 6: srst mid-transfer, then a clean 2-word command
    h0 = hs_n;
    start_cmd(8'h40, 9'd10, 1'b0);
    wait_words(h0 + 3, 40, 1'b0, "t6_three");
    srst = 1'b1;
    @(negedge clk);
    check("t6_rst_rden", rden_a, 1'b0);
    check("t6_rst_mvalid", m_valid_a, 1'b0);
    check("t6_rst_busy", busy_a, 1'b0);
    check("t6_rst_rdaddr", rdaddr_a, 8'h00);
    tick();
    @(negedge clk);
    check("t6_rst_mdata", m_data_a, 32'h0);
    tick();
    srst = 1'b0;
    @(negedge clk);
    check("t6_ready", cmd_ready_a, 1'b1);
    check("t6_no_stale", m_valid_a, 1'b0);
    h0 = hs_n;
    start_cmd(8'h50, 9'd2, 1'b0);
    wait_words(h0 + 2, 40, 1'b0, "t6_done");
    tick(); tick(); tick();
    check("t6_nwords", hs_n - h0, 2);
    check("t6_data0", hs_data[h0], memval(8'h50));
    check("t6_data1", hs_data[h0+1], memval(8'h51));
    check("t6_last0", hs_last[h0], 1'b0);
    check("t6_last1", hs_last[h0+1], 1'b1);
    check("valid_model", valid_viol, 0);
    check("stability", stab_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
